// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Puts the instruction-fetch and data-access requesters onto one shared
//   memory port. It serves one transaction at a time. It latches the winning
//   request and waits for the memory response. It then returns the read data
//   with a one-cycle done pulse to the requester it served.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   inst_req/addr          fetch request level and address
//   inst_rdata/done        fetched word and its one-cycle completion pulse
//   data_req/wen/addr/wdata data request (wen=0 means read)
//   data_rdata/done        load data and its one-cycle completion pulse
//   mem_req/wen/addr/wdata request to the memory port
//   mem_gnt                memory accepted the request this cycle
//   mem_rvalid/rdata       memory response (read data or write acknowledge)
//   stallreq               asks CTRL to stall while any requester is waiting

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_done,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              mem_req,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
  typedef enum logic {INST, DATA} owner_t;

  state_t state, state_next;
  owner_t owner, last_grant, winner;

  logic [3:0]        lat_wen;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic any_req;
  logic start;
  logic capture;

  assign any_req = inst_req | data_req;
  assign start   = (state == IDLE) && any_req;

  // A lone requester wins. When both request, the one not served last time wins.
  assign winner = (data_req && (!inst_req || last_grant == INST)) ? DATA : INST;

  // The response can arrive in the same cycle as the grant. ADDR must capture
  // it as well as WAIT.
  assign capture = ((state == ADDR) && mem_gnt && mem_rvalid) ||
                   ((state == WAIT) && mem_rvalid);

  // State register
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the value from before the edge and the order of the
  // assignments does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: state_next gets a default before the case statement, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = ADDR;
      ADDR: if (mem_gnt) state_next = mem_rvalid ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and arbitration history. Requester inputs are sampled
  // only at the IDLE->ADDR transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= INST;
      last_grant <= INST;
      lat_wen    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (start) begin
      owner      <= winner;
      last_grant <= winner;
      lat_wen    <= (winner == DATA) ? data_wen   : 4'b0000;
      lat_addr   <= (winner == DATA) ? data_addr  : inst_addr;
      lat_wdata  <= (winner == DATA) ? data_wdata : '0;
    end
  end

  // Response data. Each register holds its value until the next completion
  // for the same owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata <= '0;
      data_rdata <= '0;
    end else if (capture) begin
      if (owner == DATA) data_rdata <= mem_rdata;
      else               inst_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (state == ADDR);
  assign mem_wen   = lat_wen;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign inst_done = (state == DONE) && (owner == INST);
  assign data_done = (state == DONE) && (owner == DATA);

  assign stallreq = (inst_req & ~inst_done) | (data_req & ~data_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It drives directed scenarios with
// hand-computed expected values. Inputs change 1 ns after the rising edge.
// Outputs are sampled on the falling edge.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stallreq;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_done  (inst_done),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .mem_req    (mem_req),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stallreq   (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle's drive point, 1 ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Move to the sample point of the current cycle.
  task automatic sample();
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int mem_req_cycles;

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    check("rst_mem_req",    32'(mem_req),   0);
    check("rst_mem_addr",   mem_addr,       0);
    check("rst_inst_rdata", inst_rdata,     0);
    check("rst_done",       32'({inst_done, data_done}), 0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;                 // cycle 0
    sample();
    check("f_c0_mem_req", 32'(mem_req),  0);
    check("f_c0_stall",   32'(stallreq), 1);
    next_cycle(); mem_gnt = 1'b1;                                // cycle 1
    sample();
    check("f_c1_mem_req",  32'(mem_req),  1);
    check("f_c1_mem_addr", mem_addr,      32'hBFC0_0000);
    check("f_c1_mem_wen",  32'(mem_wen),  0);
    check("f_c1_stall",    32'(stallreq), 1);
    next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2401_0001; // cycle 2
    sample();
    check("f_c2_mem_req", 32'(mem_req),   0);
    check("f_c2_done",    32'(inst_done), 0);
    check("f_c2_stall",   32'(stallreq),  1);
    next_cycle(); mem_rvalid = 1'b0; mem_rdata = 32'h0;          // cycle 3
    sample();
    check("f_c3_done",  32'(inst_done), 1);
    check("f_c3_rdata", inst_rdata,     32'h2401_0001);
    check("f_c3_stall", 32'(stallreq),  0);
    next_cycle(); inst_req = 1'b0;                               // cycle 4
    sample();
    check("f_c4_done",  32'(inst_done), 0);
    check("f_c4_hold",  inst_rdata,     32'h2401_0001);

    // Simultaneous requests right after a reset: data wins first
    next_cycle();
    rst = 1'b1; #2; rst = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;                  // cycle 0
    data_req = 1'b1; data_addr = 32'h0000_0200; data_wen = 4'h0;
    next_cycle(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001; // cycle 1
    sample();
    check("s_c1_mem_req",  32'(mem_req), 1);
    check("s_c1_addr",     mem_addr,     32'h0000_0200);
    next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b0;             // cycle 2
    sample();
    check("s_c2_data_done", 32'(data_done), 1);
    check("s_c2_inst_done", 32'(inst_done), 0);
    check("s_c2_rdata",     data_rdata,     32'hAAAA_0001);
    check("s_c2_stall",     32'(stallreq),  1);
    next_cycle(); data_req = 1'b0;                               // cycle 3
    sample();
    check("s_c3_mem_req",   32'(mem_req),   0);
    check("s_c3_data_done", 32'(data_done), 0);
    next_cycle(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBBBB_0002; // cycle 4
    sample();
    check("s_c4_mem_req", 32'(mem_req), 1);
    check("s_c4_addr",    mem_addr,     32'h0000_0100);
    next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b0;             // cycle 5
    sample();
    check("s_c5_inst_done", 32'(inst_done), 1);
    check("s_c5_rdata",     inst_rdata,     32'hBBBB_0002);
    check("s_c5_data_keep", data_rdata,     32'hAAAA_0001);
    next_cycle(); inst_req = 1'b0;

    // Store whose grant comes after 3 cycles. The requester inputs change
    // mid-transaction and must have no effect.
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF; // cycle 0
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 2) begin data_addr = 32'h1111_1111; data_wdata = 32'h0; data_wen = 4'h3; end
      sample();
      check($sformatf("w_c%0d_mem_req", c), 32'(mem_req), 1);
      check($sformatf("w_c%0d_addr", c),    mem_addr,     32'h8000_1000);
      check($sformatf("w_c%0d_wdata", c),   mem_wdata,    32'hDEAD_BEEF);
      check($sformatf("w_c%0d_wen", c),     32'(mem_wen), 32'hF);
    end
    next_cycle(); mem_gnt = 1'b1;                                // cycle 4
    sample();
    check("w_c4_mem_req", 32'(mem_req), 1);
    next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; // cycle 5
    sample();
    check("w_c5_mem_req",   32'(mem_req),   0);
    check("w_c5_data_done", 32'(data_done), 0);
    next_cycle(); mem_rvalid = 1'b0;                             // cycle 6
    sample();
    check("w_c6_data_done", 32'(data_done), 1);
    next_cycle(); data_req = 1'b0; data_wen = 4'h0;              // cycle 7
    sample();
    check("w_c7_data_done", 32'(data_done), 0);

    // Grant and response together in ADDR: DONE follows directly
    data_req = 1'b1; data_addr = 32'h0000_0040; data_wdata = 32'h0; // cycle 0 (drive point of cycle 7 + idle)
    next_cycle(); mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    sample();
    check("g_addr", mem_addr, 32'h0000_0040);
    next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b0;
    sample();
    check("g_data_done", 32'(data_done), 1);
    check("g_rdata",     data_rdata,     32'h1234_5678);
    check("g_inst_keep", inst_rdata,     32'hBBBB_0002);
    next_cycle(); data_req = 1'b0;

    // Request still held during DONE gets served only once
    mem_req_cycles = 0;
    inst_req = 1'b1; inst_addr = 32'h0000_0800;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      mem_gnt    = (c == 1);
      mem_rvalid = (c == 1);
      mem_rdata  = (c == 1) ? 32'hCAFE_F00D : 32'h0;
      if (c == 3) inst_req = 1'b0;
      sample();
      if (mem_req) mem_req_cycles++;
      if (c == 2) begin
        check("h_done",  32'(inst_done), 1);
        check("h_rdata", inst_rdata,     32'hCAFE_F00D);
      end
    end
    check("h_one_txn", 32'(mem_req_cycles), 1);

    // Asynchronous reset during WAIT
    next_cycle();
    data_req = 1'b1; data_addr = 32'h0000_0080; data_wen = 4'h0; data_wdata = 32'h5555_AAAA; // cycle 0
    next_cycle(); mem_gnt = 1'b1;                                // cycle 1
    next_cycle(); mem_gnt = 1'b0;                                // cycle 2, in WAIT
    check("r_pre_addr", mem_addr, 32'h0000_0080);
    #2; rst = 1'b1; data_req = 1'b0;
    #1;
    check("r_mem_req",    32'(mem_req),  0);
    check("r_mem_addr",   mem_addr,      0);
    check("r_mem_wdata",  mem_wdata,     0);
    check("r_mem_wen",    32'(mem_wen),  0);
    check("r_dones",      32'({inst_done, data_done}), 0);
    check("r_inst_rdata", inst_rdata,    0);
    check("r_data_rdata", data_rdata,    0);
    next_cycle(); rst = 1'b0;
    next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("r_late_%0d_req", c),   32'(mem_req), 0);
      check($sformatf("r_late_%0d_done", c),  32'({inst_done, data_done}), 0);
      check($sformatf("r_late_%0d_stall", c), 32'(stallreq), 0);
      next_cycle(); mem_rvalid = 1'b0;
    end
    check("r_late_rdata", data_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the core's instruction-fetch and data-access requests onto a single shared memory port with a request/grant/response handshake. It serialises the two requesters, latches the winning request, waits for the memory response, and returns read data with a one-cycle done pulse. It drives a stall request to the pipeline controller while any requester is still waiting. It sits between the IF/EX stages and the external memory port, beside CTRL.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width of requesters and memory port

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
inst_req  input  1  fetch request level; held until inst_done
inst_addr  input  ADDR_W  fetch address
inst_rdata  output  DATA_W  fetched word, valid when inst_done=1
inst_done  output  1  one-cycle completion pulse for fetch
data_req  input  1  data request level; held until data_done
data_wen  input  4  byte write enables; 0 means read
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  store data
data_rdata  output  DATA_W  load data, valid when data_done=1
data_done  output  1  one-cycle completion pulse for data
mem_req  output  1  memory request valid
mem_wen  output  4  memory byte write enables
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_gnt  input  1  memory accepted request this cycle
mem_rvalid  input  1  memory response; read data valid or write acknowledged
mem_rdata  input  DATA_W  memory read data
stallreq  output  1  pipeline stall request to CTRL

Behaviour:
- Reset: state=IDLE, last_grant=INST. mem_req, mem_wen, mem_addr, mem_wdata, inst_done, data_done, inst_rdata and data_rdata are all 0. Reset is asynchronous and takes effect mid-transaction. Any outstanding memory transaction is abandoned; memory shares rst.
- FSM states: IDLE, ADDR, WAIT, DONE. Register owner (INST/DATA) records the requester being served.
- IDLE: if any req is high, pick a winner and go to ADDR.
  - Latch addr, wen and wdata from the winner. Instruction fetches use wen=0.
  - Arbitration: if only one requester is high, it wins. If both are high, the requester not equal to last_grant wins.
  - Update last_grant to the winner.
- ADDR: mem_req=1 and the mem_* outputs drive the latched fields, held stable until mem_gnt.
  - mem_gnt=1 and mem_rvalid=0: go to WAIT.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle: capture mem_rdata and go to DONE.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata into the owner's rdata register and go to DONE. mem_rvalid outside ADDR/WAIT is ignored.
- DONE: assert the owner's done for exactly this one cycle, then return to IDLE.
  - No arbitration happens in DONE, so a req still high in that cycle is not re-served.
  - The requester drops or changes its req on the cycle after done.
- Latency: req rising in IDLE at cycle 0 gives mem_req at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, done appears at cycle 3. Minimum latency is 2 cycles (gnt and rvalid together at cycle 1, done at cycle 2).
- rdata registers hold their last captured value until the next completion for the same owner. A write completion also loads data_rdata with mem_rdata; the value is don't-care.
- stallreq (combinational) = (inst_req & ~inst_done) | (data_req & ~data_done).
- Requester inputs are sampled only in IDLE; changes during ADDR/WAIT have no effect.
- Only one transaction is outstanding at a time; there is no pipelining of requests.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; mem_gnt at cycle 1; mem_rvalid with rdata 0x24010001 at cycle 2 -> mem_req=1, mem_addr=0xBFC00000, mem_wen=0 at cycle 1; inst_done=1 and inst_rdata=0x24010001 at cycle 3 only; stallreq high cycles 0-2, low at cycle 3.
- Simultaneous requests after reset: inst_req and data_req both high at cycle 0 -> data served first (last_grant=INST after reset); then inst served starting the cycle after data_done; mem_addr sequence is data address, then inst address.
- Store: data_req=1, data_wen=0xF, data_addr=0x80001000, data_wdata=0xDEADBEEF; gnt delayed 3 cycles -> mem_req, mem_addr, mem_wdata and mem_wen stay stable for all 3 cycles; data_done pulses 1 cycle after rvalid.
- Combined gnt and rvalid in ADDR with rdata=0x12345678 -> DONE the next cycle; data_done=1 and data_rdata=0x12345678; state does not pass through WAIT.
- Held req in DONE: inst_req kept high through the inst_done cycle and then dropped -> exactly one mem_req transaction is issued.
- Reset mid-WAIT: assert rst asynchronously while in WAIT -> all outputs 0 immediately, without waiting for a clock edge; after release with no reqs, mem_req stays 0 and a late mem_rvalid produces no done.
